// File: rtl/cache_assoc_if.sv
// CPU/array/memory signal bundle for the set-associative cache controller.
// master = surrounding datapath and CPU side, slave = the controller.
interface cache_assoc_if #(
  parameter int WAYS  = 2,
  parameter int WORDS = 4
);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int OFF_W = $clog2(WORDS);

  logic             rd;
  logic             wr;
  logic [WAYS-1:0]  hit;
  logic [WAYS-1:0]  valid;
  logic [WAYS-1:0]  dirty;

  logic             comp;
  logic             cache_wr;
  logic [WAYS-1:0]  cache_en;
  logic [OFF_W-1:0] cache_offset;
  logic             cache_data_sel;
  logic             mem_rd;
  logic             mem_wr;
  logic [OFF_W-1:0] mem_offset;
  logic             mem_tag_sel;
  logic [WAY_W-1:0] victim;
  logic             stall;
  logic             done;
  logic             cache_hit;
  logic             err;

  modport master (
    output rd, wr, hit, valid, dirty,
    input  comp, cache_wr, cache_en, cache_offset, cache_data_sel,
           mem_rd, mem_wr, mem_offset, mem_tag_sel, victim,
           stall, done, cache_hit, err
  );

  modport slave (
    input  rd, wr, hit, valid, dirty,
    output comp, cache_wr, cache_en, cache_offset, cache_data_sel,
           mem_rd, mem_wr, mem_offset, mem_tag_sel, victim,
           stall, done, cache_hit, err
  );
endinterface

// File: rtl/cache_assoc_ctrl.sv
// N-way write-back / write-allocate cache control FSM with round-robin replacement.
// Optional saturating statistics counters: define CACHE_STAT_CNT_EN.
module cache_assoc_ctrl #(
  parameter int WAYS    = 2,
  parameter int WORDS   = 4,
  parameter int MEM_LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  cache_assoc_if.slave   bus
`ifdef CACHE_STAT_CNT_EN
  ,
  output logic [15:0]    hit_cnt,
  output logic [15:0]    miss_cnt,
  output logic [15:0]    wb_cnt
`endif
);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int OFF_W = $clog2(WORDS);
  localparam int CNT_W = $clog2(WORDS + MEM_LAT + 1);

  localparam logic [CNT_W-1:0] CNT_WORDS = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0] CNT_LAT   = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] WB_LAST   = CNT_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(WORDS + MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, WB, FILL, RETRY} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WAY_W-1:0] victim_q, rr_ptr, pick;
  logic [WAYS-1:0]  victim_mask;
  logic             req, hit_any, all_valid, miss_start, wb_needed;

  assign req         = bus.rd ^ bus.wr;
  assign hit_any     = |bus.hit;
  assign all_valid   = &bus.valid;
  assign miss_start  = (state == IDLE) && req && !hit_any;
  assign wb_needed   = bus.valid[pick] & bus.dirty[pick];
  assign victim_mask = {{(WAYS-1){1'b0}}, 1'b1} << victim_q;

  // Invalid ways are filled first (lowest index wins); only a full set consumes the pointer.
  always_comb begin
    pick = rr_ptr;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!bus.valid[i]) pick = WAY_W'(i);
    end
  end

  // NOTE: every output and next-state value gets a default first so no branch can infer a latch.
  always_comb begin
    state_nxt          = state;
    cnt_nxt            = cnt;
    bus.comp           = 1'b0;
    bus.cache_wr       = 1'b0;
    bus.cache_en       = '0;
    bus.cache_offset   = '0;
    bus.cache_data_sel = 1'b0;
    bus.mem_rd         = 1'b0;
    bus.mem_wr         = 1'b0;
    bus.mem_offset     = '0;
    bus.mem_tag_sel    = 1'b0;
    bus.victim         = (state == IDLE) ? pick : victim_q;
    bus.stall          = 1'b0;
    bus.done           = 1'b0;
    bus.cache_hit      = 1'b0;
    bus.err            = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.rd && bus.wr) begin
          bus.err = 1'b1;
        end else if (req) begin
          bus.comp     = 1'b1;
          bus.cache_wr = bus.wr;
          if (hit_any) begin
            bus.cache_en  = bus.hit;
            bus.done      = 1'b1;
            bus.cache_hit = 1'b1;
          end else begin
            bus.cache_en = '1;
            bus.stall    = 1'b1;
            cnt_nxt      = '0;
            state_nxt    = wb_needed ? WB : FILL;
          end
        end
      end

      WB: begin
        bus.stall        = 1'b1;
        bus.cache_en     = victim_mask;
        bus.cache_offset = OFF_W'(cnt);
        bus.mem_wr       = 1'b1;
        bus.mem_offset   = OFF_W'(cnt);
        bus.mem_tag_sel  = 1'b1;
        cnt_nxt          = cnt + 1'b1;
        if (cnt == WB_LAST) begin
          cnt_nxt   = '0;
          state_nxt = FILL;
        end
      end

      FILL: begin
        bus.stall = 1'b1;
        if (cnt < CNT_WORDS) begin
          bus.mem_rd     = 1'b1;
          bus.mem_offset = OFF_W'(cnt);
        end
        // Data for the word issued MEM_LAT cycles ago is on the bus now.
        if (cnt >= CNT_LAT) begin
          bus.cache_wr       = 1'b1;
          bus.cache_data_sel = 1'b1;
          bus.cache_en       = victim_mask;
          bus.cache_offset   = OFF_W'(cnt - CNT_LAT);
        end
        cnt_nxt = cnt + 1'b1;
        if (cnt == FILL_LAST) begin
          cnt_nxt   = '0;
          state_nxt = RETRY;
        end
      end

      RETRY: begin
        bus.stall    = 1'b1;
        bus.comp     = 1'b1;
        bus.cache_wr = bus.wr;
        bus.cache_en = victim_mask;
        bus.done     = 1'b1;
        state_nxt    = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rr_ptr   <= '0;
      victim_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (miss_start) begin
        victim_q <= pick;
        if (all_valid) rr_ptr <= rr_ptr + 1'b1;
      end
    end
  end

`ifdef CACHE_STAT_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (bus.done && bus.cache_hit && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
      if (miss_start && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
      if (miss_start && wb_needed && wb_cnt != 16'hFFFF) wb_cnt <= wb_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cache_assoc_ctrl.sv
// Scoreboard bench for cache_assoc_ctrl: the driver pushes the expected transaction,
// a negedge monitor checks every memory/cache strobe and the completion against it.
module tb_cache_assoc_ctrl;
  localparam int WAYS    = 2;
  localparam int WORDS   = 4;
  localparam int MEM_LAT = 2;
  localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef struct {
    bit              is_err;
    int              lat;
    bit              chit;
    logic [WAYS-1:0] en;
    bit              wr;
    int              vic;
    int              n_rd;
    int              n_wr;
    int              n_fill;
    int              fill_start;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_assoc_if #(.WAYS(WAYS), .WORDS(WORDS)) bus ();

`ifdef CACHE_STAT_CNT_EN
  logic [15:0] hit_cnt, miss_cnt, wb_cnt;
  cache_assoc_ctrl #(.WAYS(WAYS), .WORDS(WORDS), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
  );
`else
  cache_assoc_ctrl #(.WAYS(WAYS), .WORDS(WORDS), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  int   txn_cnt  = 0;
  bit   mon_en   = 1'b0;

  // reference model state
  int m_rr   = 0;
  int m_hit  = 0;
  int m_miss = 0;
  int m_wb   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one request -> its whole expected response.
  task automatic model(input bit rd, input bit wr, input logic [WAYS-1:0] hit,
                       input logic [WAYS-1:0] valid, input logic [WAYS-1:0] dirty,
                       output exp_t e);
    int v;
    bit full;
    full = 1'b1;
    v    = m_rr;
    for (int i = 0; i < WAYS; i++) begin
      if (!valid[i] && full) begin
        v    = i;
        full = 1'b0;
      end
    end
    e = '{is_err: 1'b0, lat: 1, chit: 1'b0, en: '0, wr: wr, vic: v,
          n_rd: 0, n_wr: 0, n_fill: 0, fill_start: 0};
    if (rd && wr) begin
      e.is_err = 1'b1;
    end else if (hit != '0) begin
      e.chit = 1'b1;
      e.en   = hit;
      m_hit++;
    end else begin
      e.en         = WAYS'(1) << v;
      e.n_wr       = (valid[v] && dirty[v]) ? WORDS : 0;
      e.n_rd       = WORDS;
      e.n_fill     = WORDS;
      e.fill_start = 2 + e.n_wr;
      e.lat        = e.fill_start + WORDS + MEM_LAT;
      m_miss++;
      if (e.n_wr != 0) m_wb++;
      if (full) m_rr = (m_rr + 1) % WAYS;
    end
  endtask

  // Monitor / scoreboard
  bit   active = 1'b0;
  int   cyc, crd, cwr, cfill;
  exp_t me;

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (!active && (bus.rd || bus.wr)) begin
        active = 1'b1;
        cyc = 1; crd = 0; cwr = 0; cfill = 0;
      end else if (active) begin
        cyc++;
      end
      if (active) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 32'd1, 32'd0);
          active = 1'b0;
        end else begin
          me = exp_q[0];
          if (bus.mem_wr) begin
            check("wb_offset", 32'(bus.mem_offset), 32'(cwr));
            check("wb_cycle", 32'(cyc), 32'(2 + cwr));
            check("wb_tag_sel", 32'(bus.mem_tag_sel), 32'd1);
            check("wb_way", 32'(bus.cache_en), 32'(WAYS'(1) << me.vic));
            cwr++;
          end
          if (bus.mem_rd) begin
            check("rd_offset", 32'(bus.mem_offset), 32'(crd));
            check("rd_cycle", 32'(cyc), 32'(me.fill_start + crd));
            crd++;
          end
          if (bus.cache_wr && !bus.comp) begin
            check("fill_sel", 32'(bus.cache_data_sel), 32'd1);
            check("fill_offset", 32'(bus.cache_offset), 32'(cfill));
            check("fill_cycle", 32'(cyc), 32'(me.fill_start + MEM_LAT + cfill));
            check("fill_way", 32'(bus.cache_en), 32'(WAYS'(1) << me.vic));
            cfill++;
          end
          if (bus.done || bus.err) begin
            void'(exp_q.pop_front());
            check("is_err", 32'(bus.err), 32'(me.is_err));
            check("latency", 32'(cyc), 32'(me.lat));
            if (me.is_err) begin
              check("err_quiet", 32'({bus.done, bus.cache_wr, bus.cache_en, bus.mem_rd,
                                      bus.mem_wr, bus.stall}), 32'd0);
            end else begin
              check("cache_hit", 32'(bus.cache_hit), 32'(me.chit));
              check("done_en", 32'(bus.cache_en), 32'(me.en));
              check("done_wr", 32'(bus.cache_wr), 32'(me.wr));
              check("done_comp", 32'(bus.comp), 32'd1);
              check("done_stall", 32'(bus.stall), 32'(!me.chit));
              check("victim", 32'(bus.victim), 32'(me.vic));
              check("n_mem_rd", 32'(crd), 32'(me.n_rd));
              check("n_mem_wr", 32'(cwr), 32'(me.n_wr));
              check("n_fill", 32'(cfill), 32'(me.n_fill));
            end
            txn_cnt++;
            active = 1'b0;
          end else begin
            check("stall_busy", 32'(bus.stall), 32'd1);
          end
        end
      end
    end
  end

  bit timed_out = 1'b0;

  task automatic run(input bit rd, input bit wr, input logic [WAYS-1:0] hit,
                     input logic [WAYS-1:0] valid, input logic [WAYS-1:0] dirty);
    exp_t e;
    int   start;
    int   k;
    if (timed_out) return;
    start = txn_cnt;
    @(posedge clk);
    #1;
    bus.rd = rd; bus.wr = wr; bus.hit = hit; bus.valid = valid; bus.dirty = dirty;
    model(rd, wr, hit, valid, dirty, e);
    exp_q.push_back(e);
    k = 0;
    while (txn_cnt == start && k < 200) begin
      @(posedge clk);
      k++;
    end
    if (txn_cnt == start) begin
      check("txn_timeout", 32'd1, 32'd0);
      timed_out = 1'b1;
    end
    #1;
    bus.rd = 1'b0; bus.wr = 1'b0;
  endtask

  initial begin
    logic [WAYS-1:0] v, d, h;
    int op, w;
    bus.rd = 1'b0; bus.wr = 1'b0; bus.hit = '0; bus.valid = '0; bus.dirty = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'({bus.comp, bus.cache_wr, bus.cache_en, bus.cache_offset,
                                bus.cache_data_sel, bus.mem_rd, bus.mem_wr, bus.mem_offset,
                                bus.mem_tag_sel, bus.victim, bus.stall, bus.done,
                                bus.cache_hit, bus.err}), 32'd0);
    rst = 1'b0;

    // Clean miss abandoned by reset at FILL counter 3.
    @(posedge clk);
    #1;
    bus.rd = 1'b1; bus.valid = 2'b01;
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_mem_rd", 32'({bus.mem_rd, bus.mem_offset}), 32'({1'b1, 2'd3}));
    check("pre_rst_fill", 32'({bus.cache_wr, bus.cache_offset}), 32'({1'b1, 2'd1}));
    rst = 1'b1;
    bus.rd = 1'b0; bus.valid = '0;
    #1;
    check("async_rst_outputs", 32'({bus.comp, bus.cache_wr, bus.cache_en, bus.cache_offset,
                                    bus.cache_data_sel, bus.mem_rd, bus.mem_wr, bus.mem_offset,
                                    bus.mem_tag_sel, bus.victim, bus.stall, bus.done,
                                    bus.cache_hit, bus.err}), 32'd0);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    m_rr = 0;
    mon_en = 1'b1;

    // Directed cases.
    run(1, 0, 2'b10, 2'b11, 2'b00);
    run(1, 0, 2'b00, 2'b01, 2'b00);
    run(0, 1, 2'b00, 2'b11, 2'b11);
    run(1, 0, 2'b00, 2'b11, 2'b00);
    run(1, 1, 2'b00, 2'b11, 2'b00);
    run(0, 1, 2'b01, 2'b01, 2'b01);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      v  = WAYS'($urandom_range(0, (1 << WAYS) - 1));
      d  = WAYS'($urandom) & v;
      h  = '0;
      if (v != '0 && $urandom_range(0, 2) == 0) begin
        do w = $urandom_range(0, WAYS - 1); while (!v[w]);
        h[w] = 1'b1;
      end
      op = $urandom_range(0, 9);
      run(op == 0 || op < 5, op == 0 || op >= 5, h, v, d);
    end

    @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
`ifdef CACHE_STAT_CNT_EN
    check("hit_cnt", 32'(hit_cnt), 32'(m_hit));
    check("miss_cnt", 32'(miss_cnt), 32'(m_miss));
    check("wb_cnt", 32'(wb_cnt), 32'(m_wb));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cache_assoc_ctrl.md
Name: cache_assoc_ctrl

Overview:
- Control FSM for a parametrised N-way set-associative, write-back, write-allocate cache in front of a fixed-latency pipelined memory.
- Sits between the CPU-side request interface and the cache way arrays and memory, replacing the fixed 2-way / 4-word controller.
- Adds the following over the previous controller: a configurable way count and block size, a memory latency parameter, invalid-first victim selection, and round-robin replacement.

Parameters:
WAYS, 2, number of ways; power of 2, 2..8.
WORDS, 4, words per block; power of 2, 2..16.
MEM_LAT, 2, cycles from a mem_rd issue to the data being valid on the memory data bus; 1..8.
(Derived: WAY_W = max(1, clog2(WAYS)); OFF_W = clog2(WORDS).)

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
rd  in  1  CPU read request; held with its address until done.
wr  in  1  CPU write request; held with its address and data until done.
hit  in  WAYS  per-way tag match AND valid, for the current index.
valid  in  WAYS  per-way valid bit at the current index.
dirty  in  WAYS  per-way dirty bit at the current index.
comp  out  1  1 = compare-mode access (tag check, CPU data); 0 = access mode (fill or writeback).
cache_wr  out  1  cache write strobe.
cache_en  out  WAYS  one-hot way enable.
cache_offset  out  OFF_W  word offset driven to the cache.
cache_data_sel  out  1  1 = cache write data comes from memory (fill); 0 = from the CPU.
mem_rd  out  1  memory read issue.
mem_wr  out  1  memory write issue.
mem_offset  out  OFF_W  word offset driven to memory.
mem_tag_sel  out  1  1 = memory address uses the victim tag (writeback); 0 = the CPU tag.
victim  out  WAY_W  currently selected victim way.
stall  out  1  request in progress and not yet done.
done  out  1  single-cycle completion pulse.
cache_hit  out  1  qualifies done; 1 = the request hit on its first compare.
err  out  1  single-cycle protocol error.

Behaviour:
- Reset: state=IDLE, counter=0, round-robin pointer=0. All outputs 0 except those derived combinationally from inputs in IDLE. Reset is honoured mid-operation; a partial fill or writeback is abandoned, with no cleanup.
- Outputs are combinational from state, counter, and inputs.
- IDLE:
  - rd&wr -> err=1 for 1 cycle; no cache or memory access; remain in IDLE.
  - rd^wr -> comp=1, cache_en=all 1s, cache_wr=wr.
  - Any hit bit set -> done=1, cache_hit=1, stall=0 in the same cycle; cache_en=hit, and the write lands in the hit way.
  - No hit -> stall=1; latch the victim; next state = WB if valid[victim]&dirty[victim], else FILL.
- Victim: the lowest-index way with valid=0. If all ways are valid, victim = round-robin pointer, and the pointer increments (mod WAYS) on each IDLE->miss transition that used it.
- WB: counter 0..WORDS-1, one word per cycle.
  - comp=0, cache_en=onehot(victim), cache_offset=counter, mem_wr=1, mem_offset=counter, mem_tag_sel=1.
  - After the last word, go to FILL with counter=0.
- FILL: counter 0..WORDS+MEM_LAT-1.
  - Issue mem_rd with mem_offset=counter while counter<WORDS.
  - While counter>=MEM_LAT: cache_wr=1, comp=0, cache_data_sel=1, cache_en=onehot(victim), cache_offset=counter-MEM_LAT. These writes set the tag and valid and clear dirty.
  - Issues and writes overlap.
  - After the last count, go to RETRY.
- RETRY: repeat the IDLE compare access into the victim way.
  - done=1, cache_hit=0.
  - A write sets dirty via comp=1.
  - Return to IDLE.
- stall=1 in WB, FILL, and RETRY (RETRY included) and on the IDLE miss cycle.
- rd/wr deasserting mid-miss is a protocol violation; the FSM completes regardless.
- Miss latency, with the request cycle counted as cycle 1:
  - clean miss: done at cycle WORDS+MEM_LAT+2.
  - dirty miss: done at cycle 2*WORDS+MEM_LAT+2.

Optional Feature:
- CACHE_STAT_CNT_EN defined:
  - Adds outputs hit_cnt[15:0], miss_cnt[15:0], wb_cnt[15:0].
  - Each counter saturates at 16'hFFFF and clears on rst.
  - hit_cnt increments on done&cache_hit, miss_cnt on each IDLE->miss transition, wb_cnt on each WB entry.
- Not defined: these ports and their logic are absent, and behaviour is otherwise identical.

Test Plan (WAYS=2, WORDS=4, MEM_LAT=2):
- Read with hit=2'b10 in IDLE -> same cycle: done=1, cache_hit=1, cache_en=2'b10, stall=0; no mem_rd/mem_wr.
- Read miss, valid=2'b01 -> victim=1; mem_rd in cycles 2-5 with offsets 0..3; cache_wr in cycles 4-7 with offsets 0..3; done=1, cache_hit=0 at cycle 8.
- Write miss, valid=2'b11, dirty=2'b11, pointer=0 -> mem_wr with mem_tag_sel=1 in cycles 2-5; fill in cycles 6-11; done at cycle 12 with cache_wr=1, comp=1, cache_en=2'b01; next miss with all valid -> victim=1.
- rd=1, wr=1 in IDLE -> err=1 for one cycle; done=0; no strobes; state stays IDLE.
- rst asserted during FILL counter=3 -> all outputs 0 immediately (asynchronously); the next request hit completes in 1 cycle.
- CACHE_STAT_CNT_EN: 3 hits, 1 clean miss, 1 dirty miss -> hit_cnt=3, miss_cnt=2, wb_cnt=1.
